shifter_arbiter: RTL and testbench



---
 rtl/shifter_pkg.sv | 16 +
 rtl/barrel_shift_core.sv | 53 +++++
 rtl/shifter_arbiter.sv | 108 ++++++++++
 tb/tb_shifter_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter arbiter slice.
//   - op encodings used by the requesters and the barrel shift core
//   - output slot state encoding
package shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;  // shift left, zero fill
  localparam logic [1:0] OP_SRL = 2'b01;  // shift right, zero fill
  localparam logic [1:0] OP_SRA = 2'b10;  // shift right, sign fill
  localparam logic [1:0] OP_ROL = 2'b11;  // rotate left

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/barrel_shift_core.sv
// Purely combinational barrel shifter.
// Ports:
//   data   in  WIDTH    operand
//   shamt  in  SHAMT_W  shift amount 0..WIDTH-1
//   op     in  2        OP_SLL / OP_SRL / OP_SRA / OP_ROL
//   result out WIDTH    shifted operand
// Built as SHAMT_W stages; stage gi shifts by 2**gi when shamt[gi] is set.
// Each stage picks its shifted candidate with a 4:1 mux on op.
module barrel_shift_core
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   result
);

  logic [SHAMT_W:0][WIDTH-1:0] stage;

  assign stage[0] = data;

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] shifted;

      assign cur = stage[gi];

      // Arithmetic right shift composes across stages because every
      // stage preserves the msb, so the original sign keeps propagating.
      always_comb begin
        shifted = cur;
        case (op)
          OP_SLL:  shifted = {cur[WIDTH-1-SH:0], {SH{1'b0}}};
          OP_SRL:  shifted = {{SH{1'b0}}, cur[WIDTH-1:SH]};
          OP_SRA:  shifted = {{SH{cur[WIDTH-1]}}, cur[WIDTH-1:SH]};
          OP_ROL:  shifted = {cur[WIDTH-1-SH:0], cur[WIDTH-1:WIDTH-SH]};
          default: shifted = cur;
        endcase
      end

      assign stage[gi+1] = shamt[gi] ? shifted : cur;
    end
  endgenerate

  assign result = stage[SHAMT_W];

endmodule

// File: rtl/shifter_arbiter.sv
// Two requesters share one barrel shifter; round-robin arbitration with a
// single registered output slot.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req0_* / req1_*               valid/ready request channels
//                                 (data, shamt, op operands)
//   out_valid/out_ready           output slot handshake
//   out_data                      registered shift result
//   out_id                        requester that produced out_data
// WIDTH must equal 2**SHAMT_W.
module shifter_arbiter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_id
);

  slot_state_t      state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             id_reg, id_next;
  logic             prio_reg, prio_next;

  logic             slot_free;
  logic             grant0, grant1;
  logic             accept;
  logic [WIDTH-1:0] core_data;
  logic [SHAMT_W-1:0] core_shamt;
  logic [1:0]       core_op;
  logic [WIDTH-1:0] core_result;

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_id    = id_reg;

  // A result can be taken this cycle if the slot is empty or being drained.
  assign slot_free = !out_valid || out_ready;

  // prio names the winner when both requesters are valid.
  assign grant0 = req0_valid && (!req1_valid || !prio_reg);
  assign grant1 = req1_valid && (!req0_valid ||  prio_reg);

  assign req0_ready = grant0 && slot_free && !rst;
  assign req1_ready = grant1 && slot_free && !rst;
  assign accept     = req0_ready || req1_ready;

  // Operand mux in front of the single shifter instance.
  assign core_data  = grant1 ? req1_data  : req0_data;
  assign core_shamt = grant1 ? req1_shamt : req0_shamt;
  assign core_op    = grant1 ? req1_op    : req0_op;

  barrel_shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data   (core_data),
    .shamt  (core_shamt),
    .op     (core_op),
    .result (core_result)
  );

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    id_next    = id_reg;
    prio_next  = prio_reg;
    if (accept) begin
      // Covers the drain-and-refill case: slot is overwritten, stays FULL.
      state_next = FULL;
      data_next  = core_result;
      id_next    = grant1;
      prio_next  = !grant1;
    end else if (out_valid && out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      id_reg    <= 1'b0;
      prio_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      id_reg    <= id_next;
      prio_reg  <= prio_next;
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
module tb_shifter_arbiter;
  import shifter_pkg::*;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0_valid, req0_ready;
  logic [WIDTH-1:0]   req0_data;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [1:0]         req0_op;
  logic               req1_valid, req1_ready;
  logic [WIDTH-1:0]   req1_data;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [1:0]         req1_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_id;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } res_t;

  res_t exp_q[$];
  res_t cur;
  int   passed = 0;
  int   total  = 0;
  logic exp_prio;

  shifter_arbiter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  // Reference shifter: one bit position per iteration.
  function automatic logic [WIDTH-1:0] ref_shift(logic [WIDTH-1:0] d, int s, logic [1:0] op);
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < s; k++) begin
      case (op)
        OP_SLL:  r = {r[WIDTH-2:0], 1'b0};
        OP_SRL:  r = {1'b0, r[WIDTH-1:1]};
        OP_SRA:  r = {r[WIDTH-1], r[WIDTH-1:1]};
        default: r = {r[WIDTH-2:0], r[WIDTH-1]};
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cur();
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '0;
  endtask

  task automatic push_req(input logic n);
    res_t e;
    e.id = n;
    if (n) e.data = ref_shift(req1_data, int'(req1_shamt), req1_op);
    else   e.data = ref_shift(req0_data, int'(req0_shamt), req0_op);
    exp_q.push_back(e);
    $display("push id=%0d data=%h", e.id, e.data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_prio = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    total++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b expected 0", req0_ready); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1: got %b expected 0", req1_ready); else passed++;
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    exp_prio = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h expected 00", out_data); else passed++;
    total++; if (out_id !== 1'b0) $display("FAIL rst_id: got %b expected 0", out_id); else passed++;
    $display("reset: out_valid=%b out_data=%h out_id=%b", out_valid, out_data, out_id);
  endtask

  task automatic test_single();
    res_t e;
    out_ready  = 1'b1;
    req0_data  = 8'hB4;
    req0_shamt = 3'd3;
    req0_op    = OP_SRA;
    req0_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", req0_ready); else passed++;
    e.id = 1'b0; e.data = 8'hF6;
    exp_q.push_back(e);
    exp_prio = 1'b1;
    tick();
    req0_valid = 1'b0;
    pop_cur();
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_data !== cur.data) $display("FAIL single_data: got %h expected %h", out_data, cur.data); else passed++;
    total++; if (out_id !== cur.id) $display("FAIL single_id: got %b expected %b", out_id, cur.id); else passed++;
    $display("single: out_data=%h out_id=%b", out_data, out_id);
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_ops();
    logic [1:0]         ops  [7] = '{OP_SLL, OP_SRL, OP_ROL, OP_SRA, OP_SLL, OP_ROL, OP_SRA};
    logic [SHAMT_W-1:0] amts [7] = '{3'd1,   3'd7,   3'd1,   3'd0,   3'd0,   3'd0,   3'd7};
    logic [WIDTH-1:0]   exps [7] = '{8'h02,  8'h01,  8'h03,  8'h81,  8'h81,  8'h81,  8'hFF};
    res_t e;
    out_ready = 1'b1;
    req1_data = 8'h81;
    req1_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req1_op    = ops[i];
      req1_shamt = amts[i];
      #1;
      total++; if (req1_ready !== 1'b1) $display("FAIL ops_ready[%0d]: got %b expected 1", i, req1_ready); else passed++;
      e.id = 1'b1; e.data = exps[i];
      exp_q.push_back(e);
      tick();
      pop_cur();
      total++; if (out_valid !== 1'b1) $display("FAIL ops_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
      total++; if (out_data !== cur.data) $display("FAIL ops_data[%0d]: got %h expected %h", i, out_data, cur.data); else passed++;
      total++; if (out_id !== 1'b1) $display("FAIL ops_id[%0d]: got %b expected 1", i, out_id); else passed++;
      $display("op=%0d shamt=%0d out_data=%h out_id=%b", ops[i], amts[i], out_data, out_id);
    end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic g;
    do_reset();
    out_ready  = 1'b1;
    req0_data  = 8'($urandom); req0_shamt = 3'($urandom); req0_op = 2'($urandom);
    req1_data  = 8'($urandom); req1_shamt = 3'($urandom); req1_op = 2'($urandom);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      g = 1'(i % 2);
      #1;
      total++; if (req0_ready !== !g) $display("FAIL cont_ready0[%0d]: got %b expected %b", i, req0_ready, !g); else passed++;
      total++; if (req1_ready !== g) $display("FAIL cont_ready1[%0d]: got %b expected %b", i, req1_ready, g); else passed++;
      push_req(g);
      exp_prio = !g;
      tick();
      pop_cur();
      total++; if (out_valid !== 1'b1) $display("FAIL cont_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
      total++; if (out_id !== cur.id) $display("FAIL cont_id[%0d]: got %b expected %b", i, out_id, cur.id); else passed++;
      total++; if (out_data !== cur.data) $display("FAIL cont_data[%0d]: got %h expected %h", i, out_data, cur.data); else passed++;
      $display("contention %0d: out_id=%b out_data=%h", i, out_id, out_data);
      if (g) begin
        req1_data = 8'($urandom); req1_shamt = 3'($urandom); req1_op = 2'($urandom);
      end else begin
        req0_data = 8'($urandom); req0_shamt = 3'($urandom); req0_op = 2'($urandom);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req0_ready !== 1'b0) $display("FAIL bp_ready0[%0d]: got %b expected 0", i, req0_ready); else passed++;
      total++; if (req1_ready !== 1'b0) $display("FAIL bp_ready1[%0d]: got %b expected 0", i, req1_ready); else passed++;
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
      total++; if (out_data !== cur.data) $display("FAIL bp_data[%0d]: got %h expected %h", i, out_data, cur.data); else passed++;
      total++; if (out_id !== cur.id) $display("FAIL bp_id[%0d]: got %b expected %b", i, out_id, cur.id); else passed++;
      $display("stall %0d: out_data=%h out_id=%b", i, out_data, out_id);
    end
    out_ready = 1'b1;
    #1;
    total++; if (req0_ready !== !exp_prio) $display("FAIL bp_resume0: got %b expected %b", req0_ready, !exp_prio); else passed++;
    total++; if (req1_ready !== exp_prio) $display("FAIL bp_resume1: got %b expected %b", req1_ready, exp_prio); else passed++;
    push_req(exp_prio);
    exp_prio = !exp_prio;
    tick();
    pop_cur();
    total++; if (out_valid !== 1'b1) $display("FAIL bp_refill_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_data !== cur.data) $display("FAIL bp_refill_data: got %h expected %h", out_data, cur.data); else passed++;
    total++; if (out_id !== cur.id) $display("FAIL bp_refill_id: got %b expected %b", out_id, cur.id); else passed++;
    $display("resume: out_data=%h out_id=%b", out_data, out_id);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b0) $display("FAIL mid_rst_ready0: got %b expected 0", req0_ready); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL mid_rst_ready1: got %b expected 0", req1_ready); else passed++;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_prio = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL mid_rst_data: got %h expected 00", out_data); else passed++;
    req0_data = 8'h3C; req0_shamt = 3'd2; req0_op = OP_ROL;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL mid_grant0: got %b expected 1", req0_ready); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL mid_grant1: got %b expected 0", req1_ready); else passed++;
    push_req(1'b0);
    exp_prio = 1'b1;
    tick();
    pop_cur();
    total++; if (out_data !== cur.data) $display("FAIL mid_data: got %h expected %h", out_data, cur.data); else passed++;
    total++; if (out_id !== 1'b0) $display("FAIL mid_id: got %b expected 0", out_id); else passed++;
    $display("post-reset grant: out_data=%h out_id=%b", out_data, out_id);
  endtask

  task automatic test_rotation();
    req0_valid = 1'b0;
    req1_data = 8'hA5; req1_shamt = 3'd4; req1_op = OP_SRL;
    #1;
    total++; if (req1_ready !== 1'b1) $display("FAIL rot_alone1: got %b expected 1", req1_ready); else passed++;
    push_req(1'b1);
    exp_prio = 1'b0;
    tick();
    pop_cur();
    total++; if (out_data !== cur.data) $display("FAIL rot_alone_data: got %h expected %h", out_data, cur.data); else passed++;
    total++; if (out_id !== 1'b1) $display("FAIL rot_alone_id: got %b expected 1", out_id); else passed++;
    req1_data = 8'h5A; req1_shamt = 3'd1; req1_op = OP_SLL;
    req0_data = 8'hC3; req0_shamt = 3'd5; req0_op = OP_SRA;
    req0_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL rot_grant0: got %b expected 1", req0_ready); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL rot_grant1: got %b expected 0", req1_ready); else passed++;
    push_req(1'b0);
    tick();
    pop_cur();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total++; if (out_data !== cur.data) $display("FAIL rot_data: got %h expected %h", out_data, cur.data); else passed++;
    total++; if (out_id !== 1'b0) $display("FAIL rot_id: got %b expected 0", out_id); else passed++;
    $display("rotation: out_data=%h out_id=%b", out_data, out_id);
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rot_drain: got %b expected 0", out_valid); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_op = OP_SLL;
    req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_op = OP_SLL;
    exp_prio = 1'b0;
    cur = '0;
    test_reset();
    test_single();
    test_ops();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_rotation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
